boltzmann_sample_collector: RTL
===============================

# boltzmann_sample_collector

Statistics reader on the output side of a Boltzmann node. It watches the node state and its four neighbour bits on every Gibbs update. After an optional burn-in, it accumulates over a fixed number of sweeps:
- the node-on count;
- four node/neighbour co-activation counts.

The counts are the correlation statistics that the future training path of the node needs. Results are read back through a registered address/data port.

## Interface
Parameters:
- NUM_SWEEPS, 256, samples accumulated per run (≥1)
- BURN_IN, 16, samples discarded before accumulation (≥1; used only with COLLECTOR_BURNIN_EN)
- CNT_W, 16, width of each statistic counter

Ports:
- clk  in  1  single clock; all logic on posedge clk
- on  in  1  asynchronous active-low reset; reset asserted while low (negedge on)
- start  in  1  one-cycle request to begin a run
- sample_valid  in  1  pulse: node/neighbours hold a fresh Gibbs update this cycle
- node  in  1  Boltzmann node state
- neighbours  in  4  neighbour states, bit i pairs with weight i+1
- busy  out  1  high in BURN or COLLECT
- done  out  1  high in DONE
- rd_addr  in  3  statistic select
- rd_data  out  CNT_W  selected statistic, registered

## Operation
- States are IDLE, BURN, COLLECT and DONE.
- IDLE → (start) BURN if COLLECTOR_BURNIN_EN is defined, else COLLECT. The same edge clears all five stat counters and the sample counter.
- BURN: each sample_valid increments the sample counter. At the BURN_IN-th valid sample, the FSM goes to COLLECT and the sample counter is cleared. Burn-in samples never touch the stats.
- COLLECT: on each sample_valid:
  - cnt[0] += node
  - cnt[i] += node & neighbours[i-1], for i = 1..4
  - sample counter += 1
  - On the NUM_SWEEPS-th valid sample, that sample is included and the FSM goes to DONE.
- DONE: stats are frozen. start → BURN/COLLECT, with counters cleared as from IDLE. There is no automatic return to IDLE.
- start while busy is ignored. sample_valid in IDLE or DONE is ignored.
- start and sample_valid in the same IDLE/DONE cycle: the sample is ignored, and the run begins with cleared counters.
- Counters saturate at 2^CNT_W−1; they never wrap. The sample counter is $clog2(NUM_SWEEPS+1) bits wide, sized independently of CNT_W.
- rd_addr mapping:
  - 0 = node-on count
  - 1..4 = co-activation count with neighbours[0..3]
  - 5..7 = reads 0
- Reads are legal in any state. In BURN or COLLECT they return the live, partial value.

## Timing
- Reset (on low): state = IDLE, busy = 0, done = 0, rd_data = 0, all counters = 0. Reset is immediate and asynchronous. Taking on low mid-run aborts the run and clears the stats.
- busy rises on the clock edge after start is sampled.
- The counter update from a valid sample is visible in the cnt registers one clock after that sample.
- done rises on the same edge that registers the final sample. busy falls on that edge too.
- rd_data has 1-cycle latency: rd_addr sampled at edge N appears after edge N. This also covers a counter updated at edge N.
- Back-to-back sample_valid, one every cycle, is supported with no stalls.

## Configuration
- COLLECTOR_BURNIN_EN is the single build option.
- Defined: the BURN state exists and BURN_IN samples are discarded after every start.
- Undefined: BURN is not built, start goes straight to COLLECT, and BURN_IN is unused.

## Test plan
- **Basic run:** NUM_SWEEPS=8, burn-in on, BURN_IN=2. Send 10 valid samples with node=1 and neighbours=4'b0101. Required: done after the 10th sample, rd 0=8, 1=8, 2=0, 3=8, 4=0, 5=0.
- **Burn-in exclusion:** the first 2 samples have node=1 and the remaining 8 have node=0. Required: rd 0=0. With the macro undefined and 8 samples of node=1: done after the 8th, rd 0=8.
- **Ignored inputs:** start during COLLECT and sample_valid during IDLE/DONE leave counts and state unchanged. start+sample_valid together in DONE gives a fresh run with all counts 0.
- **Saturation:** CNT_W=3, NUM_SWEEPS=12, all samples node=1 with all neighbours=1. Required: every rd 0..4 = 7, and done after the 12th sample.
- **Reset mid-run:** drive on low after 5 COLLECT samples. Required: busy=0, done=0, and rd_data=0 immediately. Every address reads 0 after release.
- **Read latency and gaps:** sample_valid arrives every 3rd cycle, with rd_addr=0 polled during COLLECT. Required: rd_data increments exactly 2 edges after each valid sample with node=1.

Source files
------------

// File: rtl/boltzmann_sample_collector.sv
// boltzmann_sample_collector: node-on and node/neighbour co-activation counters over a sampling run.
// Build option COLLECTOR_BURNIN_EN adds a BURN phase that discards BURN_IN samples after each start.
module boltzmann_sample_collector #(
  parameter int NUM_SWEEPS = 256,
  parameter int BURN_IN    = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             on,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             node,
  input  logic [3:0]       neighbours,
  output logic             busy,
  output logic             done,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
);
  localparam int SW = $clog2(NUM_SWEEPS + 1);
  typedef enum logic [1:0] {IDLE, BURN, COLLECT, DONE} state_t;
`ifdef COLLECTOR_BURNIN_EN
  localparam state_t FIRST = BURN;
`else
  localparam state_t FIRST = COLLECT;
`endif
  state_t           state;
  logic [SW-1:0]    scnt;
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       hit;
  logic [CNT_W-1:0] sel;
  // bit 0 is the node-on term, bits 1..4 pair the node with each neighbour
  assign hit = {neighbours & {4{node}}, node};
  assign sel = (rd_addr > 3'd4) ? '0 : cnt[rd_addr];
  always_ff @(posedge clk or negedge on)
    if (!on) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      scnt    <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      rd_data <= sel;
      case (state)
        IDLE, DONE: if (start) begin
          state <= FIRST;
          busy  <= 1'b1;
          done  <= 1'b0;
          scnt  <= '0;
          for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end
`ifdef COLLECTOR_BURNIN_EN
        BURN: if (sample_valid) begin
          if (scnt == SW'(BURN_IN - 1)) begin
            state <= COLLECT;
            scnt  <= '0;
          end else scnt <= scnt + 1'b1;
        end
`endif
        COLLECT: if (sample_valid) begin
          // counters stick at all-ones instead of wrapping
          for (int i = 0; i < 5; i++) if (hit[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
          scnt <= scnt + 1'b1;
          if (scnt == SW'(NUM_SWEEPS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule
